// File: rtl/axi_pkg.sv
// Shared AXI read constants, arbiter state encoding and transfer-size helper
// for the two-port read arbiter.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_e;

  // AXI arsize encoding (log2 of bytes per beat) for the supported R widths.
  function automatic logic [2:0] arsize_for(input int dw);
    if (dw == 64) begin
      return 3'd3;
    end else begin
      return 3'd2;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the pointer port wins ties, a lone requester always
// wins, and no grant is issued unless advance is high.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       advance,
  output logic [1:0] grant
);

  // One-hot grant selection.
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter with one burst outstanding at a time.
// Define AXI_ARB_ERR_STATUS_EN to enable per-port sticky error-response status.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic [2*ADDRESS_WIDTH-1:0] m_araddr,
  input  logic [15:0]                m_arlen,
  input  logic [1:0]                 m_arvalid,
  output logic [1:0]                 m_arready,
  output logic [DATA_WIDTH-1:0]      m_rdata,
  output logic [1:0]                 m_rresp,
  output logic                       m_rlast,
  output logic [1:0]                 m_rvalid,
  input  logic [1:0]                 m_rready,
  output logic [ADDRESS_WIDTH-1:0]   araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [1:0]                 err_sticky,
  input  logic [1:0]                 err_clr
);

  localparam logic [2:0] ARSIZE_C = arsize_for(DATA_WIDTH);

  arb_state_e               state_r;
  logic                     ptr_r;
  logic                     gnt_r;
  logic [ADDRESS_WIDTH-1:0] araddr_r;
  logic [7:0]               arlen_r;
  logic                     arvalid_r;
  logic [1:0]               grant_s;
  logic                     beat_s;

  rr_arb2 u_rr_arb2 (
    .req     (m_arvalid),
    .ptr     (ptr_r),
    .advance (state_r == IDLE),
    .grant   (grant_s)
  );

  assign araddr  = araddr_r;
  assign arlen   = arlen_r;
  assign arsize  = ARSIZE_C;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_r;

  assign m_arready = grant_s;
  assign m_rdata   = rdata;
  assign m_rresp   = rresp;
  assign m_rlast   = rlast;
  assign beat_s    = (state_r == DATA) && rvalid && rready;

  // R-channel steering toward the granted port while a burst is in DATA.
  always_comb begin
    m_rvalid = 2'b00;
    rready   = 1'b0;
    if (state_r == DATA) begin
      m_rvalid = gnt_r ? {rvalid, 1'b0} : {1'b0, rvalid};
      rready   = m_rready[gnt_r];
    end else begin
      m_rvalid = 2'b00;
      rready   = 1'b0;
    end
  end

  // Arbiter FSM: grant and latch in IDLE, hold AR in ADDR, stream beats in DATA.
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 1'b0;
      gnt_r     <= 1'b0;
      araddr_r  <= {ADDRESS_WIDTH{1'b0}};
      arlen_r   <= 8'd0;
      arvalid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            gnt_r     <= grant_s[1];
            araddr_r  <= grant_s[1] ? m_araddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                                    : m_araddr[ADDRESS_WIDTH-1:0];
            arlen_r   <= grant_s[1] ? m_arlen[15:8] : m_arlen[7:0];
            arvalid_r <= 1'b1;
            state_r   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            state_r   <= DATA;
          end
        end
        DATA: begin
          // The port just served loses priority on the next contested grant.
          if (beat_s && rlast) begin
            ptr_r   <= ~gnt_r;
            state_r <= IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

`ifdef AXI_ARB_ERR_STATUS_EN
  // Sticky error flags; a new error beat beats a simultaneous clear.
  always_ff @(posedge aclk) begin
    if (rst) begin
      err_sticky <= 2'b00;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (beat_s && (gnt_r == g[0]) && (rresp != RESP_OKAY)) begin
          err_sticky[g] <= 1'b1;
        end else if (err_clr[g]) begin
          err_sticky[g] <= 1'b0;
        end else begin
          err_sticky[g] <= err_sticky[g];
        end
      end
    end
  end
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = ^err_clr;
  assign err_sticky       = 2'b00;
`endif

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter: reset, single burst,
// round-robin, AR stall, R backpressure, mid-burst reset and error status.
module tb_axi_read_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef AXI_ARB_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic [2*AW-1:0] m_araddr = '0;
  logic [15:0]   m_arlen = '0;
  logic [1:0]    m_arvalid = '0;
  logic [1:0]    m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic [1:0]    m_rvalid;
  logic [1:0]    m_rready = '0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [1:0]    err_sticky;
  logic [1:0]    err_clr = '0;

  int checks = 0;
  int failures = 0;

  axi_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .rst(rst),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    m_arvalid = 2'b00;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Stimulus only: AR handshake, then back-to-back beats with OKAY response.
  task automatic complete_burst(input int beats);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      rvalid = 1'b1;
      rresp = 2'b00;
      rdata = 32'h5000_0000 + i;
      rlast = (i == beats - 1);
      tick();
    end
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
    checks++; if (m_arready !== 2'b00) begin failures++; $display("FAIL reset_m_arready got=%b exp=00", m_arready); end
    checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL reset_m_rvalid got=%b exp=00", m_rvalid); end
    checks++; if (err_sticky !== 2'b00) begin failures++; $display("FAIL reset_err_sticky got=%b exp=00", err_sticky); end
  endtask

  task automatic test_single();
    m_rready = 2'b11;
    m_araddr = 16'h0010;
    m_arlen = 16'h0003;
    m_arvalid = 2'b01;
    #1;
    checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL single_m_arready got=%b exp=01", m_arready); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_idle got=%b exp=0", arvalid); end
    tick();
    m_arvalid = 2'b00;
    #1;
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid got=%b exp=1", arvalid); end
    checks++; if (araddr !== 8'h10) begin failures++; $display("FAIL single_araddr got=%h exp=10", araddr); end
    checks++; if (arlen !== 8'd3) begin failures++; $display("FAIL single_arlen got=%0d exp=3", arlen); end
    checks++; if (arsize !== 3'd2) begin failures++; $display("FAIL single_arsize got=%0d exp=2", arsize); end
    checks++; if (arburst !== 2'b01) begin failures++; $display("FAIL single_arburst got=%b exp=01", arburst); end
    checks++; if (m_rvalid !== 2'b00) begin failures++; $display("FAIL single_rvalid_addr got=%b exp=00", m_rvalid); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1;
      rdata = 32'hA000_0000 + i;
      rlast = (i == 3);
      #1;
      checks++; if (m_rvalid !== 2'b01) begin failures++; $display("FAIL single_m_rvalid beat=%0d got=%b exp=01", i, m_rvalid); end
      checks++; if (m_rdata !== 32'hA000_0000 + i) begin failures++; $display("FAIL single_m_rdata beat=%0d got=%h exp=%h", i, m_rdata, 32'hA000_0000 + i); end
      checks++; if (rready !== 1'b1) begin failures++; $display("FAIL single_rready beat=%0d got=%b exp=1", i, rready); end
      checks++; if (m_rlast !== (i == 3)) begin failures++; $display("FAIL single_m_rlast beat=%0d got=%b", i, m_rlast); end
      tick();
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    #1;
    checks++; if (m_rvalid !== 2'b00 || rready !== 1'b0 || arvalid !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b/%b/%b exp=00/0/0", m_rvalid, rready, arvalid); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    m_rready = 2'b11;
    m_arlen = 16'h0101;
    m_arvalid = 2'b11;
    #1;
    checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", m_arready); end
    tick();
    m_arvalid = 2'b10;
    #1;
    checks++; if (m_arready !== 2'b00) begin failures++; $display("FAIL rr_no_ready_in_addr got=%b exp=00", m_arready); end
    complete_burst(2);
    m_arvalid = 2'b11;
    #1;
    checks++; if (m_arready !== 2'b10) begin failures++; $display("FAIL rr_second got=%b exp=10", m_arready); end
    tick();
    m_arvalid = 2'b01;
    complete_burst(2);
    m_arvalid = 2'b11;
    #1;
    checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL rr_third got=%b exp=01", m_arready); end
    tick();
    m_arvalid = 2'b00;
    complete_burst(2);
  endtask

  task automatic test_ar_stall();
    m_araddr = 16'h0044;
    m_arlen = 16'h0005;
    m_arvalid = 2'b01;
    tick();
    m_arvalid = 2'b00;
    arready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 8'h44 || arlen !== 8'd5) begin failures++; $display("FAIL stall_stable cyc=%0d got=%b/%h/%0d exp=1/44/5", c, arvalid, araddr, arlen); end
      tick();
    end
    complete_burst(6);
    #1;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL stall_done_arvalid got=%b exp=0", arvalid); end
  endtask

  task automatic test_backpressure();
    logic [9:0] pat;
    int k;
    int recv;
    logic hs;
    pat = 10'b1001101101;
    k = 0;
    recv = 0;
    m_araddr = 16'h8000;
    m_arlen = 16'h0300;
    m_arvalid = 2'b10;
    #1;
    checks++; if (m_arready !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", m_arready); end
    tick();
    m_arvalid = 2'b00;
    checks++; if (araddr !== 8'h80 || arlen !== 8'd3) begin failures++; $display("FAIL bp_ar got=%h/%0d exp=80/3", araddr, arlen); end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      m_rready = {pat[c % 10], 1'b0};
      rvalid = 1'b1;
      rdata = 32'hB000_0000 + k;
      rlast = (k == 3);
      #1;
      checks++; if (rready !== pat[c % 10]) begin failures++; $display("FAIL bp_rready cyc=%0d got=%b exp=%b", c, rready, pat[c % 10]); end
      checks++; if (m_rvalid !== 2'b10) begin failures++; $display("FAIL bp_m_rvalid cyc=%0d got=%b exp=10", c, m_rvalid); end
      if (m_rvalid[1] && m_rready[1]) begin
        checks++; if (m_rdata !== 32'hB000_0000 + recv) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, m_rdata, 32'hB000_0000 + recv); end
        recv++;
      end
      hs = rvalid && rready;
      tick();
      if (hs) k++;
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    m_rready = 2'b11;
    #1;
    checks++; if (recv !== 4 || k !== 4) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=4/4", recv, k); end
    checks++; if (m_rvalid !== 2'b00 || rready !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b/%b exp=00/0", m_rvalid, rready); end
  endtask

  task automatic test_reset_mid_burst();
    m_rready = 2'b11;
    m_arlen = 16'h0700;
    m_arvalid = 2'b01;
    tick();
    m_arvalid = 2'b00;
    complete_burst(1);
    m_arvalid = 2'b10;
    tick();
    m_arvalid = 2'b00;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rvalid = 1'b1;
      rlast = 1'b0;
      tick();
    end
    rst = 1'b1;
    #1;
    checks++; if (m_rvalid !== 2'b10) begin failures++; $display("FAIL mid_pre_reset_rvalid got=%b exp=10", m_rvalid); end
    tick();
    #1;
    checks++; if (m_rvalid !== 2'b00 || rready !== 1'b0) begin failures++; $display("FAIL mid_reset_r got=%b/%b exp=00/0", m_rvalid, rready); end
    checks++; if (arvalid !== 1'b0 || m_arready !== 2'b00 || err_sticky !== 2'b00) begin failures++; $display("FAIL mid_reset_misc got=%b/%b/%b exp=0/00/00", arvalid, m_arready, err_sticky); end
    rst = 1'b0;
    rvalid = 1'b0;
    m_arlen = 16'h0000;
    m_arvalid = 2'b11;
    #1;
    checks++; if (m_arready !== 2'b01) begin failures++; $display("FAIL mid_next_grant got=%b exp=01", m_arready); end
    tick();
    m_arvalid = 2'b00;
    complete_burst(1);
  endtask

  task automatic test_err_status();
    m_rready = 2'b11;
    m_arlen = 16'h0001;
    m_arvalid = 2'b01;
    tick();
    m_arvalid = 2'b00;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1;
    rresp = 2'b10;
    rlast = 1'b0;
    #1;
    checks++; if (m_rresp !== 2'b10) begin failures++; $display("FAIL err_m_rresp got=%b exp=10", m_rresp); end
    tick();
    rresp = 2'b00;
    rlast = 1'b1;
    checks++; if (err_sticky !== (ERR_EN ? 2'b01 : 2'b00)) begin failures++; $display("FAIL err_set got=%b exp=%b", err_sticky, ERR_EN ? 2'b01 : 2'b00); end
    tick();
    rvalid = 1'b0;
    rlast = 1'b0;
    tick();
    tick();
    checks++; if (err_sticky !== (ERR_EN ? 2'b01 : 2'b00)) begin failures++; $display("FAIL err_hold got=%b exp=%b", err_sticky, ERR_EN ? 2'b01 : 2'b00); end
    err_clr = 2'b01;
    tick();
    err_clr = 2'b00;
    checks++; if (err_sticky !== 2'b00) begin failures++; $display("FAIL err_clear got=%b exp=00", err_sticky); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_backpressure();
    test_reset_mid_burst();
    test_err_status();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
